// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants for the shift_arbiter slice
package shift_arb_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam int IDW     = 1;
  localparam int DW_DEF  = 32;
  localparam int SAW_DEF = 5;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin arbiter owning the last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       accept,
  output logic [1:0] grant
);

  // last = 1 means requester 1 was granted last, so requester 0 wins a tie
  logic last;

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (accept)
      last <= grant[1];
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one external barrel shifter by two requesters
// Optional grant/conflict counters: SHIFT_ARB_STATS_EN
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int SAW = SAW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [DW-1:0]  req0_d,
  input  logic [DW-1:0]  req1_d,
  input  logic [SAW-1:0] req0_sa,
  input  logic [SAW-1:0] req1_sa,
  input  logic           req0_right,
  input  logic           req1_right,
  input  logic           req0_arith,
  input  logic           req1_arith,
  output logic [DW-1:0]  sh_d,
  output logic [SAW-1:0] sh_sa,
  output logic           sh_right,
  output logic           sh_arith,
  input  logic [DW-1:0]  sh_result,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [DW-1:0]  rsp0_data,
  output logic [DW-1:0]  rsp1_data
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [31:0]    stat_grant0,
  output logic [31:0]    stat_grant1,
  output logic [31:0]    stat_conflict
`endif
);

  state_t           state, state_nx;
  logic [IDW-1:0]   inflight_id;
  logic [1:0]       busy;
  logic [1:0]       room;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             accept;
  logic             cap0, cap1;

  // a requester with an op already in the shifter waits until it drains
  assign room     = ~rsp_valid | rsp_ready;
  assign eligible = req_valid & room & ~busy;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .accept   (accept),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = accept ? ST_SHIFT : ST_IDLE;
  end

  always_comb begin
    busy = 2'b00;
    if (state == ST_SHIFT)
      busy[inflight_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_d        <= '0;
      sh_sa       <= '0;
      sh_right    <= 1'b0;
      sh_arith    <= 1'b0;
      inflight_id <= '0;
    end else if (accept) begin
      sh_d        <= grant[1] ? req1_d     : req0_d;
      sh_sa       <= grant[1] ? req1_sa    : req0_sa;
      sh_right    <= grant[1] ? req1_right : req0_right;
      sh_arith    <= grant[1] ? req1_arith : req0_arith;
      inflight_id <= grant[1];
    end
  end

  assign cap0 = (state == ST_SHIFT) && (inflight_id == 1'b0);
  assign cap1 = (state == ST_SHIFT) && (inflight_id == 1'b1);

  // capture beats consume when both happen on the same buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 2'b00;
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else begin
      rsp_valid[0] <= cap0 | (rsp_valid[0] & ~rsp_ready[0]);
      rsp_valid[1] <= cap1 | (rsp_valid[1] & ~rsp_ready[1]);
      if (cap0)
        rsp0_data <= sh_result;
      if (cap1)
        rsp1_data <= sh_result;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // a conflict is both requesters asking with buffer room, whoever is in flight
  logic conflict;
  assign conflict = &(req_valid & room);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0])
        stat_grant0 <= stat_grant0 + 32'd1;
      if (grant[1])
        stat_grant1 <= stat_grant1 + 32'd1;
      if (conflict)
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule
